// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing: registered syncs, active-video qualifier, pixel coordinates,
// line/frame strobes and a completed-frame counter, advanced once per pixel tick.
//   state     | meaning (per axis)
//   ST_ACTIVE | count inside visible region
//   ST_FRONT  | front porch
//   ST_SYNC   | sync pulse asserted
//   ST_BACK   | back porch, leaves on count wrap to 0
module vga_timing_generator #(
  parameter int   CLK_DIV  = 1,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        display_active_o,
  output logic [8:0]  row_o,
  output logic [9:0]  column_o,
  output logic        line_start_o,
  output logic        frame_start_o,
  output logic [15:0] frame_count_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_B_FRONT = 10'(H_ACTIVE);
  localparam logic [9:0] H_B_SYNC  = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_B_BACK  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_B_FRONT = 10'(V_ACTIVE);
  localparam logic [9:0] V_B_SYNC  = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_B_BACK  = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} axis_state_e;

  function automatic axis_state_e axis_next(axis_state_e cur, logic [9:0] cnt,
                                            logic [9:0] b_front, logic [9:0] b_sync,
                                            logic [9:0] b_back);
    axis_state_e nxt;
    nxt = cur;
    case (cur)
      ST_ACTIVE: if (cnt == b_front) nxt = ST_FRONT;
      ST_FRONT:  if (cnt == b_sync)  nxt = ST_SYNC;
      ST_SYNC:   if (cnt == b_back)  nxt = ST_BACK;
      ST_BACK:   if (cnt == '0)      nxt = ST_ACTIVE;
    endcase
    return nxt;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  axis_state_e      h_st_q, h_st_d, v_st_q, v_st_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [8:0]       row_q, row_d;
  logic [9:0]       col_q, col_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic [15:0]      fc_q, fc_d;
  logic             first_q, first_d;
  logic             tick, h_wrap, v_wrap;

  assign tick   = (div_q == DIV_LAST);
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_st_d  = h_st_q;
    v_st_d  = v_st_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    row_d   = row_q;
    col_d   = col_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    fc_d    = fc_q;
    first_d = first_q;
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      h_st_d  = axis_next(h_st_q, h_cnt_d, H_B_FRONT, H_B_SYNC, H_B_BACK);
      v_st_d  = axis_next(v_st_q, v_cnt_d, V_B_FRONT, V_B_SYNC, V_B_BACK);
      hsync_d = (h_st_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d = (v_st_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      de_d    = (h_st_d == ST_ACTIVE) && (v_st_d == ST_ACTIVE);
      col_d   = de_d ? h_cnt_d : '0;
      row_d   = de_d ? v_cnt_d[8:0] : '0;
      ls_d    = (h_cnt_d == '0);
      fs_d    = ls_d && (v_cnt_d == '0);
      // the wrap out of the reset position is not a completed frame
      if (h_wrap && v_wrap) begin
        if (!first_q) fc_d = fc_q + 16'd1;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= DIV_LAST;
      h_cnt_q <= H_LAST;
      v_cnt_q <= V_LAST;
      h_st_q  <= ST_BACK;
      v_st_q  <= ST_BACK;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      first_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_st_q  <= h_st_d;
      v_st_q  <= v_st_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
      first_q <= first_d;
    end
  end

  assign hsync_o          = hsync_q;
  assign vsync_o          = vsync_q;
  assign display_active_o = de_q;
  assign row_o            = row_q;
  assign column_o         = col_q;
  assign line_start_o     = ls_q;
  assign frame_start_o    = fs_q;
  assign frame_count_o    = fc_q;

endmodule
